// File: rtl/imem_loader_pkg.sv
// -----------------------------------------------------------------------------
// imem_loader_pkg
// Shared types and constants for the instruction-memory program loader.
//   loader_state_t : loader FSM state encoding
//   HDR_PC_BYTES   : bytes in the start-PC header field
//   HDR_LEN_BYTES  : bytes in the word-count header field
//   WORD_BYTES     : bytes per instruction word
// -----------------------------------------------------------------------------
package imem_loader_pkg;

    typedef enum logic [2:0] {
        IDLE,
        HDR_PC,
        HDR_LEN,
        PAYLOAD,
        WRITE,
        CHK,
        DONE,
        DONE_ERR
    } loader_state_t;

    localparam int unsigned HDR_PC_BYTES  = 4;
    localparam int unsigned HDR_LEN_BYTES = 2;
    localparam int unsigned WORD_BYTES    = 4;

endpackage

// File: rtl/imem_program_loader_byte_word_assembler.sv
// -----------------------------------------------------------------------------
// byte_word_assembler
// Collects four bytes, big-endian, into a 32-bit word. Used for both the
// start-PC header field and every payload word.
// Ports:
//   clk          : system clock, rising edge
//   rst_n        : synchronous active-low reset
//   i_clear      : discard any partially assembled word
//   i_byte_valid : a byte is being accepted this cycle
//   i_byte       : the byte being accepted
//   o_word       : word including the byte currently presented
//   o_word_ready : pulse, the byte accepted this cycle completes a word
// -----------------------------------------------------------------------------
module byte_word_assembler
    import imem_loader_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_clear,
    input  logic        i_byte_valid,
    input  logic [7:0]  i_byte,
    output logic [31:0] o_word,
    output logic        o_word_ready
);

    // Only the first three bytes need storage; the fourth is taken straight
    // from the input so the full word is usable on the accepting edge.
    logic [23:0] r_word;
    logic [1:0]  r_count;

    assign o_word       = {r_word, i_byte};
    assign o_word_ready = i_byte_valid && (r_count == 2'(WORD_BYTES - 1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_word  <= '0;
            r_count <= '0;
        end else if (i_clear) begin
            r_word  <= '0;
            r_count <= '0;
        end else if (i_byte_valid) begin
            r_word  <= {r_word[15:0], i_byte};
            r_count <= r_count + 2'd1;
        end
    end

endmodule

// File: rtl/imem_program_loader.sv
// -----------------------------------------------------------------------------
// imem_program_loader
// Boot-time writer for the processor instruction memory. Consumes a byte
// stream: start PC (4 bytes, big-endian), word count N (2 bytes, big-endian),
// then N instruction words (4 bytes each, big-endian). Word i is written at
// start_pc + 4*i. The core is held in reset until the last word is written.
// Optional build macro LOADER_CHECKSUM_EN: a trailing byte equal to the XOR of
// all header and payload bytes is required; a mismatch parks in DONE_ERR.
// Ports:
//   clk, rst_n            : clock, synchronous active-low reset
//   in_valid/in_ready     : byte stream handshake, in_data the byte
//   reload                : one-cycle pulse restarting the load
//   mem_we/addr/wdata     : instruction-memory write port
//   start_pc              : PC presented to the core
//   cpu_rst_n             : core reset, low while loading
//   load_done             : program fully written
//   err                   : sticky protocol error (misaligned PC, bad checksum)
// -----------------------------------------------------------------------------
module imem_program_loader
    import imem_loader_pkg::*;
#(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [7:0]        in_data,
    input  logic              reload,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic [ADDR_W-1:0] start_pc,
    output logic              cpu_rst_n,
    output logic              load_done,
    output logic              err
);

`ifdef LOADER_CHECKSUM_EN
    localparam loader_state_t LAST_STATE = CHK;
`else
    localparam loader_state_t LAST_STATE = DONE;
`endif

    loader_state_t     r_state;
    loader_state_t     w_state_next;
    logic              w_in_ready;
    logic              w_take;
    logic              w_asm_valid;
    logic [31:0]       w_word;
    logic              w_word_ready;
    logic [CNT_W-1:0]  w_len_next;

    logic              r_len_idx;
    logic [CNT_W-1:0]  r_len;
    logic [ADDR_W-1:0] r_addr;
    logic [ADDR_W-1:0] r_start_pc;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [31:0]       r_mem_wdata;
    logic              r_err;
    logic              r_cpu_rst_n;
    logic              r_load_done;

    assign w_in_ready  = (r_state inside {HDR_PC, HDR_LEN, PAYLOAD, CHK});
    assign w_take      = in_valid && w_in_ready;
    assign w_asm_valid = w_take && ((r_state == HDR_PC) || (r_state == PAYLOAD));
    assign w_len_next  = CNT_W'({r_len, in_data});

    byte_word_assembler u_asm (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_clear      (r_state == IDLE),
        .i_byte_valid (w_asm_valid),
        .i_byte       (in_data),
        .o_word       (w_word),
        .o_word_ready (w_word_ready)
    );

`ifdef LOADER_CHECKSUM_EN
    logic [7:0] r_xor;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_xor <= '0;
        end else if (r_state == IDLE) begin
            r_xor <= '0;
        end else if (w_take && (r_state inside {HDR_PC, HDR_LEN, PAYLOAD})) begin
            r_xor <= r_xor ^ in_data;
        end
    end
`endif

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    w_state_next = HDR_PC;
            HDR_PC:  if (w_word_ready) w_state_next = HDR_LEN;
            HDR_LEN: begin
                if (w_take && r_len_idx) begin
                    w_state_next = (w_len_next == '0) ? LAST_STATE : PAYLOAD;
                end
            end
            PAYLOAD: if (w_word_ready) w_state_next = WRITE;
            WRITE:   w_state_next = (r_len == CNT_W'(1)) ? LAST_STATE : PAYLOAD;
`ifdef LOADER_CHECKSUM_EN
            CHK: begin
                if (w_take) w_state_next = (in_data == r_xor) ? DONE : DONE_ERR;
            end
            DONE_ERR: w_state_next = DONE_ERR;
`endif
            DONE:    w_state_next = DONE;
            default: w_state_next = IDLE;
        endcase
        // A write already in progress is still signalled this cycle; reload
        // only redirects the next state.
        if (reload) w_state_next = IDLE;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_len_idx   <= 1'b0;
            r_len       <= '0;
            r_addr      <= '0;
            r_start_pc  <= '0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_err       <= 1'b0;
            r_cpu_rst_n <= 1'b0;
            r_load_done <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_cpu_rst_n <= (w_state_next == DONE);
            r_load_done <= (w_state_next == DONE);
            case (r_state)
                IDLE: begin
                    r_len_idx <= 1'b0;
                    r_len     <= '0;
                end
                HDR_PC: begin
                    if (w_word_ready) begin
                        r_start_pc <= ADDR_W'(w_word);
                        if (w_word[1:0] != 2'b00) r_err <= 1'b1;
                    end
                end
                HDR_LEN: begin
                    if (w_take) begin
                        r_len     <= w_len_next;
                        r_len_idx <= 1'b1;
                        // Misaligned PC is flagged but loading continues aligned.
                        r_addr    <= {r_start_pc[ADDR_W-1:2], 2'b00};
                    end
                end
                PAYLOAD: begin
                    if (w_word_ready) begin
                        r_mem_addr  <= r_addr;
                        r_mem_wdata <= w_word;
                    end
                end
                WRITE: begin
                    r_addr <= r_addr + ADDR_W'(4);
                    r_len  <= r_len - CNT_W'(1);
                end
`ifdef LOADER_CHECKSUM_EN
                CHK: begin
                    if (w_take && (in_data != r_xor)) r_err <= 1'b1;
                end
`endif
                default: ;
            endcase
            if (reload) r_err <= 1'b0;
        end
    end

    assign in_ready  = w_in_ready;
    assign mem_we    = (r_state == WRITE);
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign start_pc  = r_start_pc;
    assign cpu_rst_n = r_cpu_rst_n;
    assign load_done = r_load_done;
    assign err       = r_err;

endmodule

// File: tb/tb_imem_program_loader.sv
// -----------------------------------------------------------------------------
// tb_imem_program_loader
// Directed self-checking bench for imem_program_loader. Define
// LOADER_CHECKSUM_EN for both bench and RTL to exercise the checksum build.
// -----------------------------------------------------------------------------
module tb_imem_program_loader;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_data;
    logic        reload;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] start_pc;
    logic        cpu_rst_n;
    logic        load_done;
    logic        err;

    always #5 clk = ~clk;

    imem_program_loader #(.ADDR_W(32), .CNT_W(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .reload    (reload),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .start_pc  (start_pc),
        .cpu_rst_n (cpu_rst_n),
        .load_done (load_done),
        .err       (err)
    );

    int          n_checks = 0;
    int          n_pass   = 0;
    int          cyc      = 0;
    int          last_we_cyc = -1;
    int          rise_cyc    = -1;
    logic        prev_cpu    = 1'b0;
    logic [31:0] q_addr[$];
    logic [31:0] q_data[$];
    logic [7:0]  tb_xor;
    int          byte_idx;
    bit          gap_en;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (mem_we === 1'b1) begin
            q_addr.push_back(mem_addr);
            q_data.push_back(mem_wdata);
            last_we_cyc = cyc;
        end
        if (cpu_rst_n === 1'b1 && !prev_cpu) rise_cyc = cyc;
        prev_cpu = (cpu_rst_n === 1'b1);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    task automatic send_byte(input logic [7:0] b);
        int guard;
        int g;
        if (gap_en) begin
            g = byte_idx % 3;
            repeat (g) @(negedge clk);
        end
        in_valid = 1'b1;
        in_data  = b;
        guard    = 0;
        while (!in_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (!in_ready) begin
            chk("in_ready_timeout", 32'd0, 32'd1);
            in_valid = 1'b0;
            return;
        end
        @(negedge clk);
        in_valid = 1'b0;
        tb_xor   = tb_xor ^ b;
        byte_idx++;
    endtask

    task automatic send_hdr(input logic [31:0] pc, input logic [15:0] n);
        tb_xor   = 8'h00;
        byte_idx = 0;
        for (int i = 0; i < 4; i++) send_byte(pc[31-8*i -: 8]);
        for (int i = 0; i < 2; i++) send_byte(n[15-8*i -: 8]);
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int i = 0; i < 4; i++) send_byte(w[31-8*i -: 8]);
    endtask

    task automatic send_chk(input bit good);
`ifdef LOADER_CHECKSUM_EN
        logic [7:0] c;
        c = good ? tb_xor : 8'hFF;
        send_byte(c);
`else
        if (good) return;
`endif
    endtask

    task automatic do_reload();
        reload = 1'b1;
        @(negedge clk);
        reload = 1'b0;
        q_addr.delete();
        q_data.delete();
        last_we_cyc = -1;
        rise_cyc    = -1;
        @(negedge clk);
    endtask

    task automatic check_stream1(input string pfx);
        chk({pfx, "_nwrites"}, 32'(q_addr.size()), 32'd2);
        if (q_addr.size() == 2) begin
            chk({pfx, "_addr0"}, q_addr[0], 32'h0000_02B8);
            chk({pfx, "_data0"}, q_data[0], 32'h2008_0002);
            chk({pfx, "_addr1"}, q_addr[1], 32'h0000_02BC);
            chk({pfx, "_data1"}, q_data[1], 32'h2009_0002);
        end
        chk({pfx, "_start_pc"}, start_pc, 32'd696);
        chk({pfx, "_load_done"}, 32'(load_done), 32'd1);
        chk({pfx, "_cpu_rst_n"}, 32'(cpu_rst_n), 32'd1);
        chk({pfx, "_err"}, 32'(err), 32'd0);
        chk({pfx, "_in_ready"}, 32'(in_ready), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'h00;
        reload   = 1'b0;
        gap_en   = 1'b0;
        tb_xor   = 8'h00;
        byte_idx = 0;
        repeat (3) @(negedge clk);

        chk("rst_in_ready",  32'(in_ready),  32'd0);
        chk("rst_mem_we",    32'(mem_we),    32'd0);
        chk("rst_mem_addr",  mem_addr,       32'd0);
        chk("rst_mem_wdata", mem_wdata,      32'd0);
        chk("rst_start_pc",  start_pc,       32'd0);
        chk("rst_cpu_rst_n", 32'(cpu_rst_n), 32'd0);
        chk("rst_load_done", 32'(load_done), 32'd0);
        chk("rst_err",       32'(err),       32'd0);
        rst_n = 1'b1;

        // Two-word program, continuous valid.
        send_hdr(32'h0000_02B8, 16'd2);
        send_word(32'h2008_0002);
        chk("t1_cpu_low_mid", 32'(cpu_rst_n), 32'd0);
        send_word(32'h2009_0002);
        send_chk(1'b1);
        repeat (3) @(negedge clk);
        check_stream1("t1");
        chk("t1_addr_hold", mem_addr, 32'h0000_02BC);
`ifndef LOADER_CHECKSUM_EN
        chk("t1_cpu_rise_lat", 32'(rise_cyc - last_we_cyc), 32'd1);
`endif

        do_reload();
        chk("rl_cpu_rst_n", 32'(cpu_rst_n), 32'd0);
        chk("rl_load_done", 32'(load_done), 32'd0);

        // Empty program.
        send_hdr(32'h0000_02B8, 16'd0);
        send_chk(1'b1);
        k = 0;
        while (cpu_rst_n !== 1'b1 && k < 2) begin
            @(negedge clk);
            k++;
        end
        chk("t2_cpu_rst_n", 32'(cpu_rst_n), 32'd1);
        repeat (3) @(negedge clk);
        chk("t2_nwrites",  32'(q_addr.size()), 32'd0);
        chk("t2_load_done", 32'(load_done), 32'd1);
        chk("t2_start_pc", start_pc, 32'd696);

        // Same program with gaps in in_valid.
        do_reload();
        gap_en = 1'b1;
        send_hdr(32'h0000_02B8, 16'd2);
        send_word(32'h2008_0002);
        send_word(32'h2009_0002);
        send_chk(1'b1);
        gap_en = 1'b0;
        repeat (3) @(negedge clk);
        check_stream1("t3");

        // Reload in the middle of the first payload word.
        do_reload();
        send_hdr(32'h0000_02B8, 16'd2);
        send_byte(8'h20);
        send_byte(8'h08);
        do_reload();
        chk("t4_cpu_rst_n", 32'(cpu_rst_n), 32'd0);
        chk("t4_load_done", 32'(load_done), 32'd0);
        send_hdr(32'h0000_0100, 16'd1);
        send_word(32'hDEAD_BEEF);
        send_chk(1'b1);
        repeat (3) @(negedge clk);
        chk("t4_nwrites", 32'(q_addr.size()), 32'd1);
        if (q_addr.size() == 1) begin
            chk("t4_addr0", q_addr[0], 32'h0000_0100);
            chk("t4_data0", q_data[0], 32'hDEAD_BEEF);
        end
        chk("t4_load_done_end", 32'(load_done), 32'd1);

        // Misaligned start PC.
        do_reload();
        send_hdr(32'h0000_02BA, 16'd1);
        send_word(32'h1122_3344);
        send_chk(1'b1);
        repeat (3) @(negedge clk);
        chk("t5_err", 32'(err), 32'd1);
        chk("t5_nwrites", 32'(q_addr.size()), 32'd1);
        if (q_addr.size() == 1) chk("t5_addr0", q_addr[0], 32'h0000_02B8);
        chk("t5_start_pc", start_pc, 32'h0000_02BA);
        chk("t5_load_done", 32'(load_done), 32'd1);
        do_reload();
        chk("t5_err_cleared", 32'(err), 32'd0);

`ifdef LOADER_CHECKSUM_EN
        // Wrong checksum byte.
        send_hdr(32'h0000_02B8, 16'd2);
        send_word(32'h2008_0002);
        send_word(32'h2009_0002);
        send_chk(1'b0);
        repeat (3) @(negedge clk);
        chk("t6_err", 32'(err), 32'd1);
        chk("t6_load_done", 32'(load_done), 32'd0);
        chk("t6_cpu_rst_n", 32'(cpu_rst_n), 32'd0);
        chk("t6_in_ready", 32'(in_ready), 32'd0);
        do_reload();
        send_hdr(32'h0000_02B8, 16'd2);
        send_word(32'h2008_0002);
        send_word(32'h2009_0002);
        send_chk(1'b1);
        repeat (3) @(negedge clk);
        check_stream1("t7");
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
